// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared constants for the sequential ALU.
//   - OP_* : 4-bit operation encodings presented on the op input.
//   - ST_* : FSM state encodings for the top-level controller.
//   - needs_iter() : true when an accepted operation must run on the
//     multi-cycle MUL/DIV datapath instead of completing in one cycle.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOTA = 4'd5;
  localparam logic [3:0] OP_MUL  = 4'd6;
  localparam logic [3:0] OP_DIV  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Divide-by-zero is resolved immediately, so it never enters the iterator.
  function automatic logic needs_iter(input logic [3:0] op, input logic b_zero);
    return (op == OP_MUL) || ((op == OP_DIV) && !b_zero);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle of the sequential ALU.
//   Request : in_valid, in_ready, a, b, op
//   Response: out_valid, out_ready, yl, yh, err
//   master = producer of operands / consumer of results, slave = the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] yl;
  logic [WIDTH-1:0] yh;
  logic             err;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, yl, yh, err
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, yl, yh, err
  );

endinterface

// File: rtl/alu_seq_iter.sv
// alu_seq_iter: iterative MUL (shift-add) / DIV (restoring) datapath.
//   clk, rst : clock, synchronous active-high reset
//   start    : load operands and begin WIDTH iterations
//   mode     : 0 = multiply, 1 = divide (sampled with start)
//   a, b     : unsigned operands (sampled with start)
//   lo, hi   : MUL -> product low/high; DIV -> quotient/remainder
//   done     : iteration counter is zero (result valid once started)
// Both modes share one 2*WIDTH register: the low half holds the multiplier
// (MUL) or the dividend being consumed MSB first (DIV); the high half
// accumulates the partial product or the running remainder.
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   opnd_reg;
  logic               mode_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;

  always_comb begin
    // MUL: add multiplicand when the current multiplier LSB is set,
    // then shift the whole accumulator right (carry enters from the top).
    mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
              + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    // DIV: remainder shifted left with the next dividend bit appended.
    div_shift = acc_reg[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opnd_reg};
    if (!mode_reg) begin
      acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
    end else if (!div_diff[WIDTH]) begin
      acc_next = {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
    end else begin
      // Trial subtraction went negative: restore, quotient bit 0.
      acc_next = {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg  <= '0;
      opnd_reg <= '0;
      mode_reg <= 1'b0;
      cnt_reg  <= '0;
    end else if (start) begin
      acc_reg  <= {{WIDTH{1'b0}}, (mode ? a : b)};
      opnd_reg <= mode ? b : a;
      mode_reg <= mode;
      cnt_reg  <= CNT_W'(WIDTH);
    end else if (cnt_reg != '0) begin
      acc_reg  <= acc_next;
      cnt_reg  <= cnt_reg - 1'b1;
    end
  end

  assign lo   = acc_reg[WIDTH-1:0];
  assign hi   = acc_reg[2*WIDTH-1:WIDTH];
  assign done = (cnt_reg == '0);

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with a double-width result.
//   clk, rst : clock, synchronous active-high reset
//   bus      : alu_seq_if.slave
//              in_valid/in_ready/a/b/op -> one request, accepted only in IDLE
//              out_valid/out_ready/yl/yh/err -> result, held until out_ready
// Single-cycle ops are computed combinationally from the request and
// registered at the accept edge. MUL and DIV (b != 0) run on alu_seq_iter.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);

  localparam int SH_W = $clog2(WIDTH);

  logic [1:0]         state_reg, state_next;
  logic [WIDTH-1:0]   yl_reg, yl_next;
  logic [WIDTH-1:0]   yh_reg, yh_next;
  logic               err_reg, err_next;
  logic               accept;
  logic               iter_start;
  logic [WIDTH-1:0]   iter_lo, iter_hi;
  logic               iter_done;
  logic [WIDTH:0]     add_full, sub_full;
  logic [2*WIDTH-1:0] shl_full;
  logic [WIDTH-1:0]   sc_yl, sc_yh;
  logic               sc_err;

  // Single-cycle results
  always_comb begin
    add_full = {1'b0, bus.a} + {1'b0, bus.b};
    sub_full = {1'b0, bus.a} - {1'b0, bus.b};
    shl_full = {{WIDTH{1'b0}}, bus.a} << bus.b[SH_W-1:0];
    sc_yl    = '0;
    sc_yh    = '0;
    sc_err   = 1'b0;
    case (bus.op)
      OP_ADD:  begin sc_yl = add_full[WIDTH-1:0]; sc_yh = {{(WIDTH-1){1'b0}}, add_full[WIDTH]}; end
      OP_SUB:  begin sc_yl = sub_full[WIDTH-1:0]; sc_yh = {{(WIDTH-1){1'b0}}, sub_full[WIDTH]}; end
      OP_AND:  sc_yl = bus.a & bus.b;
      OP_OR:   sc_yl = bus.a | bus.b;
      OP_XOR:  sc_yl = bus.a ^ bus.b;
      OP_NOTA: sc_yl = ~bus.a;
      OP_MUL:  sc_yl = '0;  // always iterative; this path is never selected
      OP_DIV:  begin        // only reached for b == 0
        sc_yl  = '1;
        sc_yh  = bus.a;
        sc_err = 1'b1;
      end
      OP_SHL:  begin sc_yl = shl_full[WIDTH-1:0]; sc_yh = shl_full[2*WIDTH-1:WIDTH]; end
      OP_SHR:  sc_yl = bus.a >> bus.b[SH_W-1:0];
      default: sc_err = 1'b1;
    endcase
  end

  assign accept     = (state_reg == ST_IDLE) && bus.in_valid;
  assign iter_start = accept && needs_iter(bus.op, (bus.b == '0));

  alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst   (rst),
    .start (iter_start),
    .mode  (bus.op == OP_DIV),
    .a     (bus.a),
    .b     (bus.b),
    .lo    (iter_lo),
    .hi    (iter_hi),
    .done  (iter_done)
  );

  always_comb begin
    state_next = state_reg;
    yl_next    = yl_reg;
    yh_next    = yh_reg;
    err_next   = err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (iter_start) begin
          state_next = ST_CALC;
        end else if (accept) begin
          state_next = ST_DONE;
          yl_next    = sc_yl;
          yh_next    = sc_yh;
          err_next   = sc_err;
        end
      end
      ST_CALC: begin
        // Counter is non-zero in the first CALC cycle, so this waits out
        // all WIDTH iteration steps before capturing.
        if (iter_done) begin
          state_next = ST_DONE;
          yl_next    = iter_lo;
          yh_next    = iter_hi;
          err_next   = 1'b0;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      yl_reg    <= '0;
      yh_reg    <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      yl_reg    <= yl_next;
      yh_reg    <= yh_next;
      err_reg   <= err_next;
    end
  end

  assign bus.in_ready  = (state_reg == ST_IDLE);
  assign bus.out_valid = (state_reg == ST_DONE);
  assign bus.yl        = yl_reg;
  assign bus.yh        = yh_reg;
  assign bus.err       = err_reg;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed + model-checked bench for alu_seq (WIDTH=8 and 16).
// Expected results are pushed to a scoreboard queue at accept time and
// popped when the DUT presents out_valid.
module tb_alu_seq;
  import alu_seq_pkg::*;

  typedef struct {
    logic [31:0] yl;
    logic [31:0] yh;
    logic        err;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8))  bus8 ();
  alu_seq_if #(.WIDTH(16)) bus16 ();

  alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] yl, input logic [31:0] yh,
                              input logic err, input int lat);
    exp_t e;
    e.yl = yl; e.yh = yh; e.err = err; e.lat = lat;
    return e;
  endfunction

  // Arithmetic reference for WIDTH=8
  function automatic exp_t model8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    logic [8:0]  s;
    logic [15:0] p;
    logic [7:0]  t;
    e = mk(32'd0, 32'd0, 1'b0, 1);
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; e.yl = 32'(s[7:0]); e.yh = 32'(s[8]); end
      4'd1: begin s = {1'b0, a} - {1'b0, b}; e.yl = 32'(s[7:0]); e.yh = 32'(s[8]); end
      4'd2: begin t = a & b; e.yl = 32'(t); end
      4'd3: begin t = a | b; e.yl = 32'(t); end
      4'd4: begin t = a ^ b; e.yl = 32'(t); end
      4'd5: begin t = ~a;    e.yl = 32'(t); end
      4'd6: begin p = 16'(a) * 16'(b); e.yl = 32'(p[7:0]); e.yh = 32'(p[15:8]); e.lat = 9; end
      4'd7: begin
        if (b == 8'd0) begin e.yl = 32'hFF; e.yh = 32'(a); e.err = 1'b1; end
        else begin t = a / b; e.yl = 32'(t); t = a % b; e.yh = 32'(t); e.lat = 9; end
      end
      4'd8: begin p = 16'(a) << b[2:0]; e.yl = 32'(p[7:0]); e.yh = 32'(p[15:8]); end
      4'd9: begin t = a >> b[2:0]; e.yl = 32'(t); end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  // One transaction on the 8-bit DUT; stall = cycles of out_ready=0 in DONE
  // during which in_valid is also held high to probe for an illegal accept.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                      input exp_t e, input int stall);
    exp_t got;
    int   lat;
    bit   busy_ok;
    bit   stable;
    logic [7:0] yl0, yh0;
    logic err0;
    sb.push_back(e);
    @(negedge clk);
    bus8.a = a; bus8.b = b; bus8.op = op; bus8.in_valid = 1'b1;
    check("in_ready_before_accept", 32'(bus8.in_ready), 32'd1);
    @(posedge clk);
    #1 bus8.in_valid = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    forever begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus8.out_valid === 1'b1 || lat > 64) break;
      if (bus8.in_ready !== 1'b0) busy_ok = 1'b0;
    end
    check("in_ready_low_while_busy", 32'(busy_ok), 32'd1);
    check("in_ready_low_in_done", 32'(bus8.in_ready), 32'd0);
    yl0 = bus8.yl; yh0 = bus8.yh; err0 = bus8.err;
    if (stall > 0) begin
      stable = 1'b1;
      bus8.in_valid = 1'b1; bus8.a = ~a; bus8.op = OP_ADD;
      for (int i = 0; i < stall; i++) begin
        @(posedge clk);
        @(negedge clk);
        if (bus8.yl !== yl0 || bus8.yh !== yh0 || bus8.err !== err0 ||
            bus8.out_valid !== 1'b1 || bus8.in_ready !== 1'b0) stable = 1'b0;
      end
      check("stable_under_backpressure", 32'(stable), 32'd1);
    end
    check("scoreboard_nonempty", 32'(sb.size() > 0), 32'd1);
    got = (sb.size() > 0) ? sb.pop_front() : mk(32'hDEAD, 32'hDEAD, 1'bx, -1);
    check("yl", 32'(yl0), got.yl);
    check("yh", 32'(yh0), got.yh);
    check("err", 32'(err0), 32'(got.err));
    check("latency", 32'(lat), 32'(got.lat));
    $display("txn w8 op=%0d a=0x%02h b=0x%02h -> yl=0x%02h yh=0x%02h err=%0d lat=%0d",
             op, a, b, yl0, yh0, err0, lat);
    bus8.in_valid = 1'b0;
    bus8.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus8.out_ready = 1'b0;
    check("out_valid_drops", 32'(bus8.out_valid), 32'd0);
    check("in_ready_after_done", 32'(bus8.in_ready), 32'd1);
  endtask

  initial begin
    int   lat;
    bit   saw;
    exp_t got;
    logic [3:0] rop;
    logic [7:0] ra, rb;

    bus8.in_valid = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.op = '0;  bus8.out_ready = 1'b0;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.op = '0; bus16.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_in_ready", 32'(bus8.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus8.out_valid), 32'd0);
    check("reset_yl", 32'(bus8.yl), 32'd0);
    check("reset_yh", 32'(bus8.yh), 32'd0);
    check("reset_err", 32'(bus8.err), 32'd0);

    // Directed vectors
    run8(8'h88, 8'h77, OP_ADD, mk(32'hFF, 32'h00, 1'b0, 1), 0);
    run8(8'hFF, 8'h01, OP_ADD, mk(32'h00, 32'h01, 1'b0, 1), 0);
    run8(8'h88, 8'h77, OP_SUB, mk(32'h11, 32'h00, 1'b0, 1), 0);
    run8(8'h77, 8'h88, OP_SUB, mk(32'hEF, 32'h01, 1'b0, 1), 0);
    run8(8'h88, 8'h77, OP_MUL, mk(32'h38, 32'h3F, 1'b0, 9), 0);
    run8(8'h88, 8'h77, OP_DIV, mk(32'h01, 32'h11, 1'b0, 9), 0);
    run8(8'h88, 8'h00, OP_DIV, mk(32'hFF, 32'h88, 1'b1, 1), 0);
    run8(8'h5A, 8'h3C, 4'hC,   mk(32'h00, 32'h00, 1'b1, 1), 5);
    run8(8'hFF, 8'hFF, OP_MUL, mk(32'h01, 32'hFE, 1'b0, 9), 3);
    run8(8'h81, 8'h03, OP_SHL, mk(32'h08, 32'h04, 1'b0, 1), 0);
    run8(8'h81, 8'h0B, OP_SHR, mk(32'h10, 32'h00, 1'b0, 1), 0);

    // Pseudo-random ops against the arithmetic model
    for (int i = 0; i < 12; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      run8(ra, rb, rop, model8(rop, ra, rb), 0);
    end

    // Reset at T+4 of a MUL: result must never appear
    @(negedge clk);
    bus8.a = 8'h88; bus8.b = 8'h77; bus8.op = OP_MUL; bus8.in_valid = 1'b1;
    @(posedge clk);
    #1 bus8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus8.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_calc_in_ready", 32'(bus8.in_ready), 32'd1);
    check("rst_mid_calc_yl", 32'(bus8.yl), 32'd0);
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus8.out_valid !== 1'b0) saw = 1'b1;
    end
    bus8.out_ready = 1'b0;
    check("rst_mid_calc_no_result", 32'(saw), 32'd0);
    $display("txn w8 op=6 a=0x88 b=0x77 reset at T+4 -> out_valid_seen=%0d", saw);

    // WIDTH=16 MUL 0xFFFF * 0xFFFF
    sb.push_back(mk(32'h0001, 32'hFFFE, 1'b0, 17));
    @(negedge clk);
    bus16.a = 16'hFFFF; bus16.b = 16'hFFFF; bus16.op = OP_MUL; bus16.in_valid = 1'b1;
    check("w16_in_ready", 32'(bus16.in_ready), 32'd1);
    @(posedge clk);
    #1 bus16.in_valid = 1'b0;
    lat = 0;
    forever begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus16.out_valid === 1'b1 || lat > 64) break;
    end
    got = (sb.size() > 0) ? sb.pop_front() : mk(32'hDEAD, 32'hDEAD, 1'bx, -1);
    check("w16_yl", 32'(bus16.yl), got.yl);
    check("w16_yh", 32'(bus16.yh), got.yh);
    check("w16_err", 32'(bus16.err), 32'(got.err));
    check("w16_latency", 32'(lat), 32'(got.lat));
    $display("txn w16 op=6 a=0xffff b=0xffff -> yh=0x%04h yl=0x%04h err=%0d lat=%0d",
             bus16.yh, bus16.yl, bus16.err, lat);
    bus16.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus16.out_ready = 1'b0;
    check("w16_out_valid_drops", 32'(bus16.out_valid), 32'd0);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
